// File: rtl/mult_arbiter_if.sv
// Bundle of both requester ports plus the shared result bus of mult_arbiter.
// The arbiter takes the slave side; requesters (or a bench) take the master side.
interface mult_arbiter_if;
    // port 0
    logic       req0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       gnt0;
    logic       vld0;
    logic       ack0;
    // port 1
    logic       req1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       gnt1;
    logic       vld1;
    logic       ack1;
    // shared result / status
    logic [7:0] out;
    logic       busy;
    logic       err;

    modport slave (
        input  req0, a0, b0, ack0,
        input  req1, a1, b1, ack1,
        output gnt0, vld0, gnt1, vld1,
        output out, busy, err
    );

    modport master (
        output req0, a0, b0, ack0,
        output req1, a1, b1, ack1,
        input  gnt0, vld0, gnt1, vld1,
        input  out, busy, err
    );
endinterface

// File: rtl/mult_arbiter.sv
// Two-port round-robin arbiter in front of a 4x4 unsigned multiplier.
// Operands of the winner are latched, the product is registered and held with
// a per-port valid until the owner acknowledges or the optional timeout fires.
module mult_arbiter #(
    parameter int unsigned TIMEOUT = 0,  // RESP cycles before abandoning; 0 = never
    parameter int unsigned CNT_W   = 8   // timeout counter width, TIMEOUT < 2**CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [CNT_W-1:0] TLAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [3:0]       op_a;
    logic [3:0]       op_b;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] tcnt;
    logic [7:0]       out_q;
    logic             vld0_q;
    logic             vld1_q;
    logic             err_q;

    logic             any_req;
    logic             winner;
    logic             ack_own;
    logic             tmo_hit;
    logic [7:0]       product;

    // Arbitration decision, owner ack selection and the shared multiplier
    always_comb begin
        any_req = bus.req0 | bus.req1;
        // on a tie the port that did not win last time goes; otherwise whoever asks
        winner  = (bus.req0 && bus.req1) ? ~last : bus.req1;
        ack_own = owner ? bus.ack1 : bus.ack0;
        tmo_hit = (TIMEOUT != 0) && (tcnt == TLAST);
        product = {4'b0000, op_a} * {4'b0000, op_b};
    end

    // Grant pulses are combinational from state, requests and round-robin pointer
    always_comb begin
        bus.gnt0 = !rst && (state == IDLE) && any_req && !winner;
        bus.gnt1 = !rst && (state == IDLE) && any_req &&  winner;
        bus.vld0 = vld0_q;
        bus.vld1 = vld1_q;
        bus.out  = out_q;
        bus.busy = (state != IDLE);
        bus.err  = err_q;
    end

    // Main control: grant/latch in IDLE, capture product in CALC, wait for ack in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            out_q  <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
            err_q  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            owner  <= 1'b0;
            last   <= 1'b1;
            tcnt   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a  <= winner ? bus.a1 : bus.a0;
                        op_b  <= winner ? bus.b1 : bus.b0;
                        owner <= winner;
                        last  <= winner;
                        state <= CALC;
                    end
                end
                CALC: begin
                    out_q <= product;
                    if (owner) vld1_q <= 1'b1;
                    else       vld0_q <= 1'b1;
                    tcnt  <= '0;
                    state <= RESP;
                end
                RESP: begin
                    if (ack_own) begin
                        vld0_q <= 1'b0;
                        vld1_q <= 1'b0;
                        state  <= IDLE;
                    end else if (tmo_hit) begin
                        vld0_q <= 1'b0;
                        vld1_q <= 1'b0;
                        err_q  <= 1'b1;
                        state  <= IDLE;
                    end else if (TIMEOUT != 0) begin
                        tcnt <= tcnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: two instances (no timeout and TIMEOUT=4)
// driven in lockstep, checked against a transaction-level model every cycle,
// plus a directed vector table with hand-derived expectations.
module tb_mult_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       r0, k0, r1, k1;
    logic [3:0] a0, b0, a1, b1;

    mult_arbiter_if bus0 ();
    mult_arbiter_if bus4 ();

    assign bus0.req0 = r0;  assign bus0.a0 = a0;  assign bus0.b0 = b0;  assign bus0.ack0 = k0;
    assign bus0.req1 = r1;  assign bus0.a1 = a1;  assign bus0.b1 = b1;  assign bus0.ack1 = k1;
    assign bus4.req0 = r0;  assign bus4.a0 = a0;  assign bus4.b0 = b0;  assign bus4.ack0 = k0;
    assign bus4.req1 = r1;  assign bus4.a1 = a1;  assign bus4.b1 = b1;  assign bus4.ack1 = k1;

    mult_arbiter #(.TIMEOUT(0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    mult_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int checks = 0;
    int passed = 0;

    // ---------------- reference model (one per instance) ----------------
    // An operation is "active" from the edge after its grant; age counts the
    // cycles since that grant (1 = product being computed, >=2 = result shown).
    int m_act [2];
    int m_age [2];
    int m_own [2];
    int m_last[2];
    int m_prod[2];
    int m_out [2];
    int m_err [2];

    function automatic int winner_of(int k);
        if (r0 && r1) return 1 - m_last[k];
        return r0 ? 0 : 1;
    endfunction

    function automatic logic [13:0] model_out(int k);
        logic g0, g1, v0, v1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst && m_act[k] == 0 && (r0 || r1)) begin
            if (winner_of(k) == 0) g0 = 1'b1;
            else                   g1 = 1'b1;
        end
        v0 = (m_act[k] != 0) && (m_age[k] >= 2) && (m_own[k] == 0);
        v1 = (m_act[k] != 0) && (m_age[k] >= 2) && (m_own[k] == 1);
        return {g0, g1, v0, v1, (m_act[k] != 0), (m_err[k] != 0), 8'(m_out[k])};
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int tmo;
            int w;
            tmo = (k == 1) ? 4 : 0;
            if (rst) begin
                m_act[k]  = 0;
                m_out[k]  = 0;
                m_err[k]  = 0;
                m_last[k] = 1;
            end else begin
                m_err[k] = 0;
                if (m_act[k] == 0) begin
                    if (r0 || r1) begin
                        w         = winner_of(k);
                        m_act[k]  = 1;
                        m_age[k]  = 1;
                        m_own[k]  = w;
                        m_last[k] = w;
                        m_prod[k] = (w == 1) ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
                    end
                end else if (m_age[k] == 1) begin
                    m_age[k] = 2;
                    m_out[k] = m_prod[k];
                end else if ((m_own[k] == 1) ? k1 : k0) begin
                    m_act[k] = 0;
                end else if (tmo != 0 && m_age[k] - 2 == tmo - 1) begin
                    m_act[k] = 0;
                    m_err[k] = 1;
                end else begin
                    m_age[k] = m_age[k] + 1;
                end
            end
        end
    endtask

    function automatic logic [13:0] dut_out(int k);
        if (k == 0)
            return {bus0.gnt0, bus0.gnt1, bus0.vld0, bus0.vld1, bus0.busy, bus0.err, bus0.out};
        return {bus4.gnt0, bus4.gnt1, bus4.vld0, bus4.vld1, bus4.busy, bus4.err, bus4.out};
    endfunction

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: {g0,g1,v0,v1,busy,err} got %b out %h, expected %b out %h",
                      nm, act[13:8], act[7:0], exp[13:8], exp[7:0]);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic run_cycle(input string tag, input bit use_tbl, input bit sel4,
                             input logic [13:0] exp);
        @(negedge clk);
        check({tag, ".t0"}, dut_out(0), model_out(0));
        check({tag, ".t4"}, dut_out(1), model_out(1));
        if (use_tbl) check({tag, sel4 ? ".tbl4" : ".tbl0"}, dut_out(sel4 ? 1 : 0), exp);
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       sel4;
        bit       rst;
        bit       r0;
        bit [3:0] a0, b0;
        bit       k0;
        bit       r1;
        bit [3:0] a1, b1;
        bit       k1;
        bit [5:0] fl;   // expected {gnt0,gnt1,vld0,vld1,busy,err}
        bit [7:0] o;    // expected out
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit s, input bit rs,
                       input bit q0, input bit [3:0] x0, input bit [3:0] y0, input bit c0,
                       input bit q1, input bit [3:0] x1, input bit [3:0] y1, input bit c1,
                       input bit [5:0] fl, input bit [7:0] o);
        vec_t v;
        v.sel4 = s;  v.rst = rs;
        v.r0 = q0;   v.a0 = x0;  v.b0 = y0;  v.k0 = c0;
        v.r1 = q1;   v.a1 = x1;  v.b1 = y1;  v.k1 = c1;
        v.fl = fl;   v.o = o;
        vq.push_back(v);
    endtask

    initial begin
        // single request from port 0 (reset row also shows gnt held low in reset)
        add(0,1, 1,1,1,0, 0,0,0,0, 6'b000000, 8'h00);
        add(0,0, 1,1,1,0, 0,0,0,0, 6'b100000, 8'h00);
        add(0,0, 0,1,1,0, 0,0,0,0, 6'b000010, 8'h00);
        add(0,0, 0,1,1,1, 0,0,0,0, 6'b001010, 8'h01);
        add(0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 8'h01);
        // port 1 alone, 8*2, held five cycles, foreign ack ignored
        add(0,0, 0,0,0,0, 1,8,2,0, 6'b010000, 8'h01);
        add(0,0, 0,0,0,0, 0,8,2,0, 6'b000010, 8'h01);
        add(0,0, 0,0,0,0, 0,8,2,0, 6'b000110, 8'h10);
        add(0,0, 0,0,0,1, 0,8,2,0, 6'b000110, 8'h10);
        add(0,0, 0,0,0,1, 0,8,2,0, 6'b000110, 8'h10);
        add(0,0, 0,0,0,0, 0,8,2,0, 6'b000110, 8'h10);
        add(0,0, 0,0,0,0, 0,8,2,0, 6'b000110, 8'h10);
        add(0,0, 0,0,0,0, 0,8,2,1, 6'b000110, 8'h10);
        add(0,0, 0,0,0,0, 0,8,2,0, 6'b000000, 8'h10);
        // both requesting: 0, then 1, then 0 again
        add(0,0, 1,2,2,0, 1,15,15,0, 6'b100000, 8'h10);
        add(0,0, 1,2,2,0, 1,15,15,0, 6'b000010, 8'h10);
        add(0,0, 1,2,2,1, 1,15,15,0, 6'b001010, 8'h04);
        add(0,0, 1,2,2,0, 1,15,15,0, 6'b010000, 8'h04);
        add(0,0, 1,2,2,0, 1,15,15,0, 6'b000010, 8'h04);
        add(0,0, 1,2,2,0, 1,15,15,1, 6'b000110, 8'hE1);
        add(0,0, 1,2,2,0, 1,15,15,0, 6'b100000, 8'hE1);
        add(0,0, 0,2,2,0, 0,15,15,0, 6'b000010, 8'hE1);
        add(0,0, 0,2,2,1, 0,15,15,0, 6'b001010, 8'h04);
        add(0,0, 0,0,0,0, 0,0,0,0,   6'b000000, 8'h04);
        // reset while port 1 holds a result, then a tie goes to port 0
        add(0,0, 0,0,0,0, 1,8,2,0, 6'b010000, 8'h04);
        add(0,0, 0,0,0,0, 0,8,2,0, 6'b000010, 8'h04);
        add(0,0, 0,0,0,0, 0,8,2,0, 6'b000110, 8'h10);
        add(0,1, 1,2,2,0, 1,8,2,0, 6'b000110, 8'h10);
        add(0,0, 1,2,2,0, 1,8,2,0, 6'b100000, 8'h00);
        add(0,0, 0,2,2,0, 0,8,2,0, 6'b000010, 8'h00);
        add(0,0, 0,2,2,1, 0,8,2,0, 6'b001010, 8'h04);
        add(0,0, 0,0,0,0, 0,0,0,0, 6'b000000, 8'h04);
        // TIMEOUT=4 instance: 3*5 never acknowledged
        add(1,0, 1,3,5,0, 0,0,0,0, 6'b100000, 8'h04);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b000010, 8'h04);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b001010, 8'h0F);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b001010, 8'h0F);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b001010, 8'h0F);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b001010, 8'h0F);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b000001, 8'h0F);
        add(1,0, 0,3,5,1, 0,0,0,0, 6'b000000, 8'h0F);
        // TIMEOUT=4 instance: ack lands on the edge the timeout would fire
        add(1,0, 1,3,5,0, 0,0,0,0, 6'b100000, 8'h0F);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b000010, 8'h0F);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b001010, 8'h0F);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b001010, 8'h0F);
        add(1,0, 0,3,5,0, 0,0,0,0, 6'b001010, 8'h0F);
        add(1,0, 0,3,5,1, 0,0,0,0, 6'b001010, 8'h0F);
        add(1,0, 0,0,0,0, 0,0,0,0, 6'b000000, 8'h0F);

        // initial reset cycle, outputs not yet defined
        rst = 1'b1;
        r0 = 1'b0; a0 = '0; b0 = '0; k0 = 1'b0;
        r1 = 1'b0; a1 = '0; b1 = '0; k1 = 1'b0;
        @(posedge clk);
        model_step();
        #1;

        foreach (vq[i]) begin
            rst = vq[i].rst;
            r0 = vq[i].r0;  a0 = vq[i].a0;  b0 = vq[i].b0;  k0 = vq[i].k0;
            r1 = vq[i].r1;  a1 = vq[i].a1;  b1 = vq[i].b1;  k1 = vq[i].k1;
            run_cycle($sformatf("tbl[%0d]", i), 1'b1, vq[i].sel4, {vq[i].fl, vq[i].o});
        end

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            r0  = ($urandom_range(0, 2) != 0);
            r1  = ($urandom_range(0, 2) != 0);
            a0  = 4'($urandom);
            b0  = 4'($urandom);
            a1  = 4'($urandom);
            b1  = 4'($urandom);
            k0  = ($urandom_range(0, 9) < 3);
            k1  = ($urandom_range(0, 9) < 3);
            run_cycle($sformatf("rnd[%0d]", n), 1'b0, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
